// File: rtl/softmax_normalizer.sv
// rtl/softmax_normalizer.sv - collects a row of exp() scores, then emits each score / row sum as UQ0.8
// Nine-step restoring divider per weight; single row buffer, no overlap between rows.
module softmax_normalizer #(
  parameter int N_SCORES = 4,
  parameter int IDX_W    = $clog2(N_SCORES),
  parameter int SUM_W    = 9 + IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [7:0]       out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy
);

  typedef enum logic [1:0] {COLLECT, DIV, OUT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SCORES - 1);

  state_t             state, state_nxt;
  logic [8:0]         score_buf [N_SCORES];
  logic [SUM_W-1:0]   sum;
  logic [IDX_W-1:0]   cnt, idx;
  logic [3:0]         step;
  logic [SUM_W:0]     rem, rem_cur, rem_nxt, sum_ext;
  logic [8:0]         quo, quo_nxt;
  logic               q_bit;
  logic [7:0]         weight;
  logic               in_fire, out_fire;

  assign in_rdy   = (state == COLLECT);
  assign out_vld  = (state == OUT);
  assign busy     = (state != COLLECT);
  assign out_idx  = idx;
  assign out_last = (state == OUT) && (idx == LAST_IDX);
  assign in_fire  = in_vld && in_rdy;
  assign out_fire = out_vld && out_rdy;

  // Step 0 loads the score itself; later steps shift the partial remainder.
  always_comb begin
    sum_ext = {1'b0, sum};
    rem_cur = (step == 4'd0) ? {{(SUM_W-8){1'b0}}, score_buf[idx]} : {rem[SUM_W-1:0], 1'b0};
    q_bit   = (rem_cur >= sum_ext);
    rem_nxt = q_bit ? (rem_cur - sum_ext) : rem_cur;
    quo_nxt = {quo[7:0], q_bit};
    if (sum == '0)
      weight = 8'h00;
    else if (quo_nxt[8])
      weight = 8'hFF;
    else
      weight = quo_nxt[7:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (in_fire && cnt == LAST_IDX) state_nxt = DIV;
      DIV:     if (step == 4'd8) state_nxt = OUT;
      OUT:     if (out_fire) state_nxt = (idx == LAST_IDX) ? COLLECT : DIV;
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SCORES; i++) score_buf[i] <= '0;
      sum      <= '0;
      cnt      <= '0;
      idx      <= '0;
      step     <= '0;
      rem      <= '0;
      quo      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            score_buf[cnt] <= in_data;
            sum            <= sum + SUM_W'(in_data);
            cnt            <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              idx  <= '0;
              step <= '0;
            end
          end
        end
        DIV: begin
          rem  <= rem_nxt;
          quo  <= quo_nxt;
          step <= step + 4'd1;
          if (step == 4'd8) begin
            out_data <= weight;
            step     <= '0;
          end
        end
        OUT: begin
          if (out_fire) begin
            if (idx == LAST_IDX) begin
              sum <= '0;
              cnt <= '0;
              idx <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_normalizer.sv
// tb/tb_softmax_normalizer.sv - randomized scoreboard bench for softmax_normalizer
module tb_softmax_normalizer;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [8:0]    in_data;
  logic          in_vld;
  logic          in_rdy;
  logic [7:0]    out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_vld;
  logic          out_rdy;
  logic          busy;

  softmax_normalizer #(.N_SCORES(N)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    d;
    logic [IW-1:0] i;
    logic          l;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_ev  = 0;
  int   stall    = 0;
  int   rdy_mode = 0;
  bit   prev_vld = 0;
  bit   prev_stalled = 0;
  logic [7:0]    h_d;
  logic [IW-1:0] h_i;
  logic          h_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'($urandom_range(0, 1));
      2:       out_rdy = (stall >= 5);
      default: out_rdy = 1'b0;
    endcase
  end

  // Monitor: every output handshake pops the next expected weight.
  always @(negedge clk) begin
    if (!rst) begin
      check("rdy_exclusive", {31'd0, in_rdy & out_vld}, 32'd0);
      check("busy_vs_in_rdy", {31'd0, busy}, {31'd0, !in_rdy});
      if (out_vld && !prev_vld) check("latency", cyc - last_ev, 9);
      if (out_vld && prev_vld && prev_stalled) begin
        check("hold_data", out_data, h_d);
        check("hold_idx", out_idx, h_i);
        check("hold_last", out_last, h_l);
      end
      if (out_vld) begin
        if (out_rdy) begin
          if (q_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got data %0d idx %0d with empty scoreboard", out_data, out_idx);
          end else begin
            exp_t e;
            e = q_exp.pop_front();
            check("out_data", out_data, e.d);
            check("out_idx", out_idx, e.i);
            check("out_last", out_last, e.l);
          end
          last_ev = cyc + 1;
          stall = 0;
          prev_stalled = 0;
        end else begin
          stall++;
          prev_stalled = 1;
          h_d = out_data;
          h_i = out_idx;
          h_l = out_last;
        end
      end else begin
        prev_stalled = 0;
      end
      prev_vld = out_vld;
    end
  end

  // Reference: weight = floor(v*256/sum), clipped to 255, zero when the row sums to zero.
  task automatic push_row(input logic [8:0] v[N]);
    int s;
    int q;
    exp_t e;
    s = 0;
    for (int i = 0; i < N; i++) s += int'(v[i]);
    for (int i = 0; i < N; i++) begin
      q = (s == 0) ? 0 : (int'(v[i]) * 256) / s;
      if (q > 255) q = 255;
      e.d = 8'(q);
      e.i = IW'(i);
      e.l = (i == N - 1);
      q_exp.push_back(e);
    end
  endtask

  task automatic send_row(input logic [8:0] v[N], input bit bub, input int count);
    int t;
    if (count == N) push_row(v);
    for (int i = 0; i < count; i++) begin
      if (bub) begin
        in_vld = 1'b0;
        @(posedge clk); #1;
      end
      in_data = v[i];
      in_vld  = 1'b1;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (in_rdy) break;
        t++;
        if (t > 400) break;
      end
      if (t > 400) begin
        check("in_accept_timeout", 32'd1, 32'd0);
        in_vld = 1'b0;
        return;
      end
      @(posedge clk); #1;
      last_ev = cyc;
      in_vld = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q_exp.size() != 0 || !in_rdy) && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", q_exp.size(), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_in_rdy", in_rdy, 1);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals();
    q_exp.delete();
    stall = 0;
    in_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [8:0] row[N];

  initial begin
    rst = 1'b1;
    in_vld = 1'b0;
    in_data = '0;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    rdy_mode = 0;
    row = '{9'd64, 9'd64, 9'd64, 9'd64};   send_row(row, 0, N);
    row = '{9'd100, 9'd50, 9'd25, 9'd25};  send_row(row, 0, N);
    row = '{9'd511, 9'd0, 9'd0, 9'd0};     send_row(row, 0, N);
    row = '{9'd0, 9'd0, 9'd0, 9'd0};       send_row(row, 0, N);
    wait_idle();

    rdy_mode = 2;
    row = '{9'd10, 9'd20, 9'd30, 9'd40};   send_row(row, 0, N);
    wait_idle();

    rdy_mode = 0;
    row = '{9'd100, 9'd50, 9'd25, 9'd25};  send_row(row, 1, N);
    row = '{9'd64, 9'd64, 9'd64, 9'd64};   send_row(row, 0, N);
    wait_idle();

    // Reset mid-collect, mid-division and mid-output.
    row = '{9'd10, 9'd20, 9'd30, 9'd40};   send_row(row, 0, 2);
    do_reset();
    send_row(row, 0, N);
    repeat (4) @(posedge clk);
    do_reset();
    rdy_mode = 3;
    send_row(row, 0, N);
    for (int t = 0; t < 50 && !out_vld; t++) begin
      @(posedge clk); #1;
    end
    check("out_vld_before_reset", out_vld, 1);
    repeat (2) @(posedge clk);
    do_reset();
    rdy_mode = 0;
    row = '{9'd64, 9'd64, 9'd64, 9'd64};   send_row(row, 0, N);
    wait_idle();

    rdy_mode = 1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++)
        row[i] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom_range(0, 511));
      send_row(row, 1'($urandom_range(0, 1)), N);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
